sdram_slot_arb: RTL and testbench
=================================

// Module: sdram_slot_arb
// PURPOSE
//  Round-robin arbiter that shares one 32-bit channel of the dual-channel SDRAM controller between
//  NREQ requesters (CPU, DMA, CD block). Mirrors the controller's 16-cycle slot counter from 'sync'.
//  Presents at most one transaction per slot frame, aligned to the controller's latch cycle.
//  Returns the write ack or read data to the winning requester with a req/ack handshake.
// PARAMETERS
//  NREQ       3   number of requesters (2..4)
//  LATCH_SLOT 15  slot in which the controller samples channel inputs
//  DONE_SLOT  12  slot (next frame) in which read data on mem_dout is valid
// PORTS
//  clk        in   1        memory clock, same clock as SDRAM controller
//  rst_n      in   1        asynchronous reset, active low
//  sync       in   1        controller frame sync; falling edge forces slot counter to 7
//  sdram_rdy  in   1        controller init complete
//  req        in   NREQ     per-requester request; held high until ack
//  req_addr   in   NREQx21  per-requester address [21:1]
//  req_din    in   NREQx32  per-requester write data
//  req_we     in   NREQx4   per-requester byte enables; nonzero = write
//  ack        out  NREQ     one-cycle completion pulse per requester
//  rdata      out  32       read data of last completed read, held
//  mem_addr   out  21       to controller addr_x0
//  mem_din    out  32       to controller din_x
//  mem_wr     out  4        to controller wr_x
//  mem_rd     out  1        to controller rd_x
//  mem_dout   in   32       from controller dout_x0
// BEHAVIOUR
//  Reset: slot=0, state IDLE, rr pointer=NREQ-1, ack=0, rdata=0, mem_wr=0, mem_rd=0, mem_addr=0, mem_din=0.
//  Slot counter: 4-bit, +1 per clk, wraps 15->0; sync falling edge (registered sync_old) loads 7.
//  States: IDLE -> (grant at slot LATCH_SLOT-1) ISSUE -> write: IDLE; read: WAIT -> (slot DONE_SLOT) IDLE.
//  Grant: only in IDLE with sdram_rdy=1, evaluated when slot==LATCH_SLOT-1.
//   Winner = first req set scanning from ptr+1 upward, modulo NREQ; ptr <= winner.
//   Same edge registers mem_addr/mem_din/mem_wr=req_we/mem_rd=(req_we==0) from winner.
//   Stable through LATCH_SLOT.
//  ISSUE: at slot 0 clear mem_wr and mem_rd (other mem_* hold). Write: ack[winner]=1 this cycle, go IDLE.
//   Read: go WAIT.
//  WAIT: at slot DONE_SLOT: rdata <= mem_dout, ack[winner]=1 for one cycle, go IDLE.
//   Grant at slot 14 of the same frame is allowed.
//  Throughput: one transaction per 16 clk. Latency from grant edge: write 2 clk, read 14 clk.
//  ack is never asserted for a requester whose grant was not issued; at most one ack bit high.
//  req dropped before ack: transaction still completes, ack still pulses (requester ignores it).
//  sync falling edge while ISSUE/WAIT: abort, mem_wr/mem_rd <= 0, no ack, IDLE. Requester is re-granted.
//   Ptr is not advanced (ptr restored to previous value).
//  sdram_rdy low: no new grant; in-flight transaction aborted as for sync. Outputs mem_wr/mem_rd forced 0.
//  Simultaneous req from all requesters: served 0,1,2,0,... one per frame; no requester starves beyond NREQ frames.
//  rst_n asserted mid-transaction: immediate return to reset values, controller sees no further request.
// TESTING
//  Reset, sdram_rdy=1, req[0] write addr=0x000100 din=0xDEADBEEF we=0xF -> mem_* valid at slot 14..15, ack[0] at slot 0.
//  req[1] read addr=0x000200, model returns 0x12345678 on mem_dout at slot 12 -> ack[1] at slot 12, rdata=0x12345678.
//  req=3'b111 held continuously -> grants 0,1,2,0 in consecutive frames, each ack exactly 16 clk apart.
//  Read granted, sync falling edge at slot 4 of WAIT -> no ack, mem_rd=0, same requester re-granted next frame.
//  sdram_rdy=0 with req=3'b001 for 64 clk -> no mem_wr/mem_rd, no ack; raise sdram_rdy -> grant at next slot 14.
//  rst_n pulsed low during WAIT -> all outputs at reset values within the same cycle; ack never pulses.

Source files
------------

// File: rtl/sdram_slot_arb.sv
// sdram_slot_arb: round-robin arbiter sharing one 32-bit channel of the SDRAM
// controller between NREQ requesters. A local copy of the controller's 16-slot
// frame counter (re-aligned by the falling edge of sync) decides when a request
// is presented, so each transaction lines up with the controller's latch slot.
// Completion is signalled back to the winner with a one-cycle ack pulse.
module sdram_slot_arb #(
  parameter int NREQ       = 3,
  parameter int LATCH_SLOT = 15,
  parameter int DONE_SLOT  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sync,
  input  logic                  sdram_rdy,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0][20:0] req_addr,
  input  logic [NREQ-1:0][31:0] req_din,
  input  logic [NREQ-1:0][3:0]  req_we,
  output logic [NREQ-1:0]       ack,
  output logic [31:0]           rdata,
  output logic [20:0]           mem_addr,
  output logic [31:0]           mem_din,
  output logic [3:0]            mem_wr,
  output logic                  mem_rd,
  input  logic [31:0]           mem_dout
);

  localparam int         PW         = (NREQ > 2) ? 2 : 1;
  // Requests are registered one slot ahead so they are stable in the latch slot.
  localparam logic [3:0] GRANT_SLOT = 4'(LATCH_SLOT - 1);
  // First slot after the latch slot: the controller has taken the request.
  localparam logic [3:0] ISSUE_END  = 4'((LATCH_SLOT + 1) % 16);
  localparam logic [3:0] DONE_S     = 4'(DONE_SLOT);
  localparam logic [3:0] SYNC_SLOT  = 4'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      slot_q, slot_d;
  logic            sync_old_q;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   ptr_save_q, ptr_save_d;
  logic [PW-1:0]   win_q, win_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [20:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_din_q, mem_din_d;
  logic [3:0]      mem_wr_q, mem_wr_d;
  logic            mem_rd_q, mem_rd_d;

  logic            sync_fall;
  logic            abort;
  logic            found;
  logic [PW-1:0]   win_idx;
  int              cand;

  assign sync_fall = sync_old_q & ~sync;
  // Any frame realignment or loss of controller readiness kills the in-flight access.
  assign abort     = sync_fall | ~sdram_rdy;

  // Round-robin winner search, starting just after the last granted requester
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr_q) + k) % NREQ;
      if (!found && req[cand[PW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[PW-1:0];
      end
    end
  end

  // Next-state logic: slot counter, FSM, grant capture, completion and abort
  always_comb begin
    state_d    = state_q;
    slot_d     = sync_fall ? SYNC_SLOT : slot_q + 4'd1;
    ptr_d      = ptr_q;
    ptr_save_d = ptr_save_q;
    win_d      = win_q;
    ack_d      = '0;
    rdata_d    = rdata_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_wr_d   = mem_wr_q;
    mem_rd_d   = mem_rd_q;
    case (state_q)
      ST_IDLE: begin
        // A realignment edge means the slot number is not trustworthy: skip the grant.
        if (sdram_rdy && !sync_fall && slot_q == GRANT_SLOT && found) begin
          ptr_save_d = ptr_q;
          ptr_d      = win_idx;
          win_d      = win_idx;
          mem_addr_d = req_addr[win_idx];
          mem_din_d  = req_din[win_idx];
          mem_wr_d   = req_we[win_idx];
          mem_rd_d   = (req_we[win_idx] == 4'd0);
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          // Undo the pointer move so the same requester wins again.
          mem_wr_d = 4'd0;
          mem_rd_d = 1'b0;
          ptr_d    = ptr_save_q;
          state_d  = ST_IDLE;
        end else if (slot_q == ISSUE_END) begin
          mem_wr_d = 4'd0;
          mem_rd_d = 1'b0;
          if (mem_rd_q) begin
            state_d = ST_WAIT;
          end else begin
            ack_d[win_q] = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      ST_WAIT: begin
        if (abort) begin
          mem_wr_d = 4'd0;
          mem_rd_d = 1'b0;
          ptr_d    = ptr_save_q;
          state_d  = ST_IDLE;
        end else if (slot_q == DONE_S) begin
          rdata_d      = mem_dout;
          ack_d[win_q] = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      slot_q     <= 4'd0;
      sync_old_q <= 1'b0;
      ptr_q      <= PW'(NREQ - 1);
      ptr_save_q <= PW'(NREQ - 1);
      win_q      <= '0;
      ack_q      <= '0;
      rdata_q    <= 32'd0;
      mem_addr_q <= 21'd0;
      mem_din_q  <= 32'd0;
      mem_wr_q   <= 4'd0;
      mem_rd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      sync_old_q <= sync;
      ptr_q      <= ptr_d;
      ptr_save_q <= ptr_save_d;
      win_q      <= win_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_wr_q   <= mem_wr_d;
      mem_rd_q   <= mem_rd_d;
    end
  end

  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  // The controller must never see a command while it is not ready.
  assign mem_wr   = mem_wr_q & {4{sdram_rdy}};
  assign mem_rd   = mem_rd_q & sdram_rdy;

endmodule

// File: tb/tb_sdram_slot_arb.sv
// Testbench for sdram_slot_arb: directed scenarios followed by random traffic,
// all checked every cycle against a latency-based transaction model.
`timescale 1ns/1ps
module tb_sdram_slot_arb;
  localparam int NREQ = 3;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  sync = 1'b1;
  logic                  sdram_rdy = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ-1:0][20:0] req_addr = '0;
  logic [NREQ-1:0][31:0] req_din = '0;
  logic [NREQ-1:0][3:0]  req_we = '0;
  logic [NREQ-1:0]       ack;
  logic [31:0]           rdata;
  logic [20:0]           mem_addr;
  logic [31:0]           mem_din;
  logic [3:0]            mem_wr;
  logic                  mem_rd;
  logic [31:0]           mem_dout = '0;

  always #5 clk = ~clk;

  sdram_slot_arb #(.NREQ(NREQ), .LATCH_SLOT(15), .DONE_SLOT(12)) dut (
    .clk(clk), .rst_n(rst_n), .sync(sync), .sdram_rdy(sdram_rdy),
    .req(req), .req_addr(req_addr), .req_din(req_din), .req_we(req_we),
    .ack(ack), .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_dout(mem_dout)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: transactions are tracked by edges elapsed since their grant.
  int              m_slot, m_ptr, m_ptr_save, m_win, m_age;
  bit              m_sync_old, m_busy, m_is_read;
  logic [NREQ-1:0] m_ack;
  logic [31:0]     m_rdata, m_din;
  logic [20:0]     m_addr;
  logic [3:0]      m_wr;
  bit              m_rd;
  int              edge_n = 0;
  int              m_grant_edge, m_last_lat, m_last_win, m_last_ack_edge;
  logic [31:0]     rd_value = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_slot = 0; m_sync_old = 0; m_busy = 0; m_ptr = NREQ - 1; m_ptr_save = NREQ - 1;
    m_win = 0; m_age = 0; m_is_read = 0; m_ack = '0; m_rdata = 0; m_addr = 0;
    m_din = 0; m_wr = 0; m_rd = 0;
  endtask

  task automatic model_finish();
    m_ack[m_win]    = 1'b1;
    m_busy          = 0;
    m_last_lat      = edge_n - m_grant_edge;
    m_last_win      = m_win;
    m_last_ack_edge = edge_n;
  endtask

  task automatic model_edge();
    bit fall;
    int prev_slot, c;
    edge_n++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    fall       = m_sync_old && !sync;
    m_sync_old = sync;
    prev_slot  = m_slot;
    m_slot     = fall ? 7 : (m_slot + 1) % 16;
    m_ack      = '0;
    if (m_busy) begin
      m_age++;
      if (fall || !sdram_rdy) begin
        m_busy = 0; m_wr = 0; m_rd = 0; m_ptr = m_ptr_save;
      end else if (m_age == 2) begin
        m_wr = 0; m_rd = 0;
        if (!m_is_read) model_finish();
      end else if (m_is_read && m_age == 14) begin
        m_rdata = mem_dout;
        model_finish();
      end
    end else if (sdram_rdy && !fall && prev_slot == 14 && req != 0) begin
      m_ptr_save = m_ptr;
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (req[c]) begin
          m_win = c;
          break;
        end
      end
      m_ptr        = m_win;
      m_busy       = 1;
      m_age        = 0;
      m_grant_edge = edge_n;
      m_addr       = req_addr[m_win];
      m_din        = req_din[m_win];
      m_wr         = req_we[m_win];
      m_is_read    = (req_we[m_win] == 4'd0);
      m_rd         = m_is_read;
    end
  endtask

  task automatic compare_all();
    check("ack", ack, m_ack);
    check("rdata", rdata, m_rdata);
    check("mem_addr", mem_addr, m_addr);
    check("mem_din", mem_din, m_din);
    check("mem_wr", mem_wr, m_wr & {4{sdram_rdy}});
    check("mem_rd", mem_rd, m_rd & sdram_rdy);
  endtask

  // One clock: drive read data for the done slot, model the edge, compare at negedge.
  task automatic step();
    mem_dout = (m_slot == 12) ? rd_value : $urandom();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    model_reset();
    #1 compare_all();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input int maxc, output bit got);
    got = 0;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (m_ack != 0) begin
        got = 1;
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    bit got;
    int cnt, bad, acks;
    int wins[4];
    int edges[4];

    model_reset();
    @(negedge clk);

    // T1: single write from requester 0
    do_reset();
    check("t1_reset_rdata", rdata, 32'h0);
    check("t1_reset_ack", ack, 3'b000);
    req_addr[0] = 21'h000100; req_din[0] = 32'hDEADBEEF; req_we[0] = 4'hF; req = 3'b001;
    for (int i = 0; i < 40 && m_slot != 15; i++) step();
    check("t1_addr", mem_addr, 21'h000100);
    check("t1_din", mem_din, 32'hDEADBEEF);
    check("t1_wr", mem_wr, 4'hF);
    check("t1_rd", mem_rd, 1'b0);
    wait_ack(40, got);
    check("t1_ack_seen", got, 1'b1);
    check("t1_ack", ack, 3'b001);
    check("t1_latency", m_last_lat, 2);
    req = '0;
    step();
    check("t1_ack_pulse", ack, 3'b000);

    // T2: read from requester 1
    do_reset();
    rd_value = 32'h12345678;
    req_addr[1] = 21'h000200; req_we[1] = 4'h0; req = 3'b010;
    wait_ack(60, got);
    check("t2_ack_seen", got, 1'b1);
    check("t2_ack", ack, 3'b010);
    check("t2_rdata", rdata, 32'h12345678);
    check("t2_latency", m_last_lat, 14);
    req = '0;
    for (int i = 0; i < 5; i++) step();
    check("t2_rdata_hold", rdata, 32'h12345678);

    // T3: all requesters held high, writes
    do_reset();
    req_we = {4'hF, 4'hF, 4'hF};
    req = 3'b111;
    for (int n = 0; n < 4; n++) begin
      wait_ack(40, got);
      check("t3_ack_seen", got, 1'b1);
      wins[n]  = m_last_win;
      edges[n] = m_last_ack_edge;
    end
    check("t3_win0", wins[0], 0);
    check("t3_win1", wins[1], 1);
    check("t3_win2", wins[2], 2);
    check("t3_win3", wins[3], 0);
    for (int n = 1; n < 4; n++) check("t3_spacing", edges[n] - edges[n-1], 16);
    req = '0;

    // T4: read aborted by sync falling edge in WAIT; ptr must be restored
    do_reset();
    rd_value = 32'h12345678;
    req_we[1] = 4'h0; req = 3'b010;
    for (int i = 0; i < 80 && !(m_busy && m_is_read && m_slot == 4); i++) step();
    check("t4_in_wait", (m_busy && m_is_read && m_slot == 4), 1'b1);
    sync = 1'b0;
    req[2] = 1'b1; req_we[2] = 4'hF;
    step();
    check("t4_no_ack", ack, 3'b000);
    check("t4_rd_cleared", mem_rd, 1'b0);
    wait_ack(60, got);
    check("t4_regrant_seen", got, 1'b1);
    check("t4_regrant_ack", ack, 3'b010);
    check("t4_regrant_rdata", rdata, 32'h12345678);
    req = '0;
    sync = 1'b1;
    step();

    // T5: controller not ready holds everything off
    do_reset();
    sdram_rdy = 1'b0;
    req_we[0] = 4'hF; req_addr[0] = 21'h1ABCD; req = 3'b001;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (ack != 0 || mem_wr != 0 || mem_rd != 0) bad++;
    end
    check("t5_idle_while_not_rdy", bad, 0);
    sdram_rdy = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      cnt++;
      if (mem_wr != 0) break;
    end
    check("t5_grant_within_frame", (cnt <= 16), 1'b1);
    check("t5_grant_wr", mem_wr, 4'hF);
    wait_ack(10, got);
    check("t5_ack_seen", got, 1'b1);
    req = '0;

    // T6: asynchronous reset during WAIT
    do_reset();
    req_we[1] = 4'h0; req_addr[1] = 21'h000200; req = 3'b010;
    for (int i = 0; i < 80 && !(m_busy && m_is_read && m_age >= 4); i++) step();
    check("t6_in_wait", (m_busy && m_is_read && m_age >= 4), 1'b1);
    rst_n = 1'b0;
    req = '0;
    model_reset();
    #1;
    check("t6_ack", ack, 3'b000);
    check("t6_rdata", rdata, 32'h0);
    check("t6_addr", mem_addr, 21'h0);
    check("t6_din", mem_din, 32'h0);
    check("t6_wr", mem_wr, 4'h0);
    check("t6_rd", mem_rd, 1'b0);
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ack != 0) acks++;
    end
    check("t6_no_ack_after_reset", acks, 0);

    // Random traffic with occasional sync realignment and readiness drops
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rd_value = $urandom();
      for (int i = 0; i < NREQ; i++) begin
        if (m_ack[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i]      = 1'b1;
          req_addr[i] = 21'($urandom());
          req_din[i]  = $urandom();
          req_we[i]   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        end else if (req[i] && $urandom_range(0, 199) == 0) begin
          req[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 149) == 0) sync = ~sync;
      if (sdram_rdy && $urandom_range(0, 299) == 0) sdram_rdy = 1'b0;
      else if (!sdram_rdy && $urandom_range(0, 9) == 0) sdram_rdy = 1'b1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
